// File: rtl/sti_dac_gen_pkg.sv
// sti_dac_pkg: FSM states, length codes and frame helpers for sti_dac_gen.
// STI_PARITY_EN adds a PARITY state used to send the trailing parity bit.
package sti_dac_pkg;

    // Widest supported frame (4*PIX_W with PIX_W up to 16)
    localparam int MAX_FRAME_W = 64;
    localparam int HALF_W      = MAX_FRAME_W / 2;

    localparam logic [1:0] LEN_1X = 2'd0;
    localparam logic [1:0] LEN_2X = 2'd1;
    localparam logic [1:0] LEN_3X = 2'd2;
    localparam logic [1:0] LEN_4X = 2'd3;

`ifdef STI_PARITY_EN
    typedef enum logic [2:0] {IDLE, SHIFT, FLUSH, DONE, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
`endif

    function automatic int unsigned frame_bits(
        input logic [1:0]  len,
        input int unsigned pix_w
    );
        return (32'(len) + 32'd1) * pix_w;
    endfunction

    // Place the payload inside the frame according to length/fill/low.
    function automatic logic [MAX_FRAME_W-1:0] align_frame(
        input logic [HALF_W-1:0] data,
        input logic [1:0]        len,
        input logic              fill,
        input logic              low,
        input int unsigned       pix_w
    );
        logic [MAX_FRAME_W-1:0] w_d;
        logic [MAX_FRAME_W-1:0] w_pmask;
        logic [MAX_FRAME_W-1:0] w_frame;
        w_d     = MAX_FRAME_W'(data);
        w_pmask = (MAX_FRAME_W'(1) << pix_w) - MAX_FRAME_W'(1);
        w_frame = '0;
        case (len)
            LEN_1X:  w_frame = low ? ((w_d >> pix_w) & w_pmask)
                                   : (w_d & w_pmask);
            LEN_2X:  w_frame = w_d;
            LEN_3X:  w_frame = fill ? (w_d << pix_w) : w_d;
            LEN_4X:  w_frame = fill ? (w_d << (2 * pix_w)) : w_d;
            default: w_frame = '0;
        endcase
        return w_frame;
    endfunction

endpackage

// File: rtl/sti_dac_gen_if.sv
// sti_dac_if: frame request, serial output and pixel-memory write bus.
// master drives load/payload, slave is the sti_dac_gen engine.
interface sti_dac_if #(
    parameter int PIX_W  = 8,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              load;
    logic              pi_ready;
    logic [DATA_W-1:0] pi_data;
    logic [1:0]        pi_length;
    logic              pi_fill;
    logic              pi_msb;
    logic              pi_low;
    logic              pi_end;
    logic              so_data;
    logic              so_valid;
    logic              pixel_wr;
    logic [ADDR_W-1:0] pixel_addr;
    logic [PIX_W-1:0]  pixel_dataout;
    logic              pixel_finish;

    modport master (
        output load, pi_data, pi_length, pi_fill,
        output pi_msb, pi_low, pi_end,
        input  pi_ready, so_data, so_valid,
        input  pixel_wr, pixel_addr, pixel_dataout,
        input  pixel_finish
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill,
        input  pi_msb, pi_low, pi_end,
        output pi_ready, so_data, so_valid,
        output pixel_wr, pixel_addr, pixel_dataout,
        output pixel_finish
    );

endinterface

// File: rtl/sti_pix_packer.sv
// sti_pix_packer: packs the serial stream MSB-first into PIX_W pixels,
// drives the registered write strobe, address counter and full flag.
module sti_pix_packer #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_bit,
    input  logic              i_bit_valid,
    input  logic              i_flush,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [PIX_W-1:0]  o_data,
    output logic              o_full_next
);
    localparam int BCNT_W = $clog2(PIX_W);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic [PIX_W-2:0]  r_shift;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]  r_data;
    logic              r_full;
    logic [PIX_W-1:0]  w_pixel;
    logic              w_group_done;
    logic              w_full_next;

    assign w_pixel      = {r_shift, i_bit};
    assign w_group_done = i_bit_valid
                        && (r_bcnt == BCNT_W'(PIX_W - 1));
    // A write in flight to the last address counts as full already
    assign w_full_next  = r_full
                        | (r_wr & (r_addr == ADDR_LAST));

    // Collect incoming bits and count position within the pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_bcnt  <= '0;
        end else if (i_bit_valid) begin
            r_shift <= w_pixel[PIX_W-2:0];
            r_bcnt  <= w_group_done ? '0 : r_bcnt + BCNT_W'(1);
        end
    end

    // Registered write strobe and data for pixels and zero-fill
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr   <= 1'b0;
            r_data <= '0;
        end else begin
            r_wr <= 1'b0;
            if (w_group_done) begin
                r_wr <= ~w_full_next;
                if (!w_full_next) r_data <= w_pixel;
            end else if (i_flush) begin
                r_wr <= ~w_full_next;
                if (!w_full_next) r_data <= '0;
            end
        end
    end

    // Advance address after each write; saturate and flag full at the top
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_full <= 1'b0;
        end else if (r_wr) begin
            if (r_addr == ADDR_LAST) r_full <= 1'b1;
            else                     r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_wr        = r_wr;
    assign o_addr      = r_addr;
    assign o_data      = r_data;
    assign o_full_next = w_full_next;

endmodule

// File: rtl/sti_dac_gen.sv
// sti_dac_gen: serial transmit + pixel pack engine with end-of-data flush.
// Define STI_PARITY_EN to append an even-parity bit after every frame.
module sti_dac_gen
    import sti_dac_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    sti_dac_if.slave bus
);
    localparam int FRAME_W = 4 * PIX_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    state_t                 r_state;
    state_t                 w_next;
    logic [FRAME_W-1:0]     r_sh;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      w_data;
    logic [MAX_FRAME_W-1:0] w_aligned;
    logic [FRAME_W-1:0]     w_frame;
    logic [FRAME_W-1:0]     w_load_sh;
    int unsigned            w_len_bits;
    logic [CNT_W-1:0]       w_cnt_init;
    logic                   w_accept;
    logic                   w_bit_valid;
    logic                   w_flush;
    logic                   w_full_next;

    assign w_data     = bus.pi_data;
    assign w_aligned  = align_frame(HALF_W'(w_data), bus.pi_length,
                                    bus.pi_fill, bus.pi_low, PIX_W);
    assign w_frame    = w_aligned[FRAME_W-1:0];
    assign w_len_bits = frame_bits(bus.pi_length, PIX_W);
    assign w_cnt_init = CNT_W'(w_len_bits - 1);
    assign w_accept   = (r_state == IDLE) & bus.load & ~bus.pi_end;
    assign w_flush    = (r_state == FLUSH);

    if (FRAME_W < MAX_FRAME_W) begin : g_hi
        logic w_unused_hi;
        assign w_unused_hi = ^w_aligned[MAX_FRAME_W-1:FRAME_W];
    end

    // Orient the frame so the next bit to send is always the MSB
    always_comb begin
        w_load_sh = '0;
        if (bus.pi_msb) begin
            w_load_sh = w_frame << (FRAME_W - w_len_bits);
        end else begin
            for (int i = 0; i < FRAME_W; i++)
                w_load_sh[i] = w_frame[FRAME_W-1-i];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; end-of-data wins over a simultaneous load
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.pi_end)
                    w_next = w_full_next ? DONE : FLUSH;
                else if (bus.load)
                    w_next = SHIFT;
            end
            SHIFT: begin
`ifdef STI_PARITY_EN
                if (r_cnt == '0) w_next = PARITY;
`else
                if (r_cnt == '0) w_next = IDLE;
`endif
            end
`ifdef STI_PARITY_EN
            PARITY: w_next = IDLE;
`endif
            FLUSH: if (w_full_next) w_next = DONE;
            DONE:  w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Frame shift register and remaining-bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sh  <= w_load_sh;
            r_cnt <= w_cnt_init;
        end else if (r_state == SHIFT) begin
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef STI_PARITY_EN
    logic r_par;

    // Running XOR of the transmitted frame bits
    always_ff @(posedge clk) begin
        if (reset)                   r_par <= 1'b0;
        else if (w_accept)           r_par <= 1'b0;
        else if (r_state == SHIFT)   r_par <= r_par ^ r_sh[FRAME_W-1];
    end
`endif

    // Moore outputs decoded from the current state
    always_comb begin
        bus.pi_ready     = 1'b0;
        bus.so_valid     = 1'b0;
        bus.so_data      = 1'b0;
        bus.pixel_finish = 1'b0;
        w_bit_valid      = 1'b0;
        unique case (r_state)
            IDLE: bus.pi_ready = 1'b1;
            SHIFT: begin
                bus.so_valid = 1'b1;
                bus.so_data  = r_sh[FRAME_W-1];
                w_bit_valid  = 1'b1;
            end
`ifdef STI_PARITY_EN
            PARITY: begin
                bus.so_valid = 1'b1;
                bus.so_data  = r_par;
            end
`endif
            DONE: bus.pixel_finish = 1'b1;
            default: ;
        endcase
    end

    sti_pix_packer #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_bit       (r_sh[FRAME_W-1]),
        .i_bit_valid (w_bit_valid),
        .i_flush     (w_flush),
        .o_wr        (bus.pixel_wr),
        .o_addr      (bus.pixel_addr),
        .o_data      (bus.pixel_dataout),
        .o_full_next (w_full_next)
    );

endmodule
